// File: rtl/siacmd_pkg.sv
// Shared constants, FSM state types and the TX request payload for the siacmd parser.
package siacmd_pkg;
  localparam int unsigned WORK_W    = 640;
  localparam int unsigned TARGET_W  = 64;
  localparam int unsigned WORK_LEN  = (WORK_W + TARGET_W) / 8;
  localparam int unsigned NONCE_LEN = 4;
  // Assembly buffer omits the final payload byte, which is taken straight from rx_data.
  localparam int unsigned ASM_W     = WORK_W + TARGET_W - 8;

  localparam logic [7:0] HDR_RX   = 8'hAA;
  localparam logic [7:0] HDR_TX   = 8'h55;
  localparam logic [7:0] CMD_WORK = 8'h00;
  localparam logic [7:0] CMD_LOOP = 8'h01;

  typedef enum logic [1:0] {R_IDLE, R_CMD, R_LEN, R_DATA} rx_state_e;
  typedef enum logic [2:0] {T_IDLE, T_HDR, T_CMD, T_LEN, T_DATA} tx_state_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [31:0] payload;
  } tx_req_t;
endpackage

// File: rtl/siacmd_tx_framer.sv
// Serialises one reply frame (0x55, cmd, len, payload LSB byte first) over the UART handshake.
module siacmd_tx_framer
  import siacmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  tx_req_t    req_data_i,
  input  logic       tx_busy_i,
  output logic       ack_c_o,
  output logic       done_c_o,
  output logic [7:0] tx_data_o,
  output logic       new_tx_data_o,
  output logic       tx_last_byte_o
);
  tx_state_e  state_q, state_d;
  tx_req_t    frame_q;
  logic [1:0] idx_q;
  logic [7:0] tx_data_q;
  logic       new_tx_data_q, tx_last_q;
  logic       send_c, last_c;
  logic [7:0] byte_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= T_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      T_IDLE:  if (req_i) state_d = T_HDR;
      T_HDR:   if (send_c) state_d = T_CMD;
      T_CMD:   if (send_c) state_d = T_LEN;
      T_LEN:   if (send_c) state_d = T_DATA;
      T_DATA:  if (send_c && last_c) state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  // A byte may go out only when the UART is free and the previous cycle carried no strobe.
  always_comb begin
    send_c   = (state_q != T_IDLE) && !tx_busy_i && !new_tx_data_q;
    last_c   = (state_q == T_DATA) && ({6'd0, idx_q} == frame_q.len - 8'd1);
    ack_c_o  = (state_q == T_IDLE) && req_i;
    done_c_o = send_c && last_c;
    byte_c   = 8'h00;
    case (state_q)
      T_HDR:   byte_c = HDR_TX;
      T_CMD:   byte_c = frame_q.cmd;
      T_LEN:   byte_c = frame_q.len;
      T_DATA:  byte_c = frame_q.payload[{idx_q, 3'b000} +: 8];
      default: byte_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q       <= '0;
      idx_q         <= 2'd0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      tx_last_q     <= 1'b0;
    end else begin
      if (ack_c_o) begin
        frame_q <= req_data_i;
        idx_q   <= 2'd0;
      end
      if (send_c && state_q == T_DATA) idx_q <= idx_q + 2'd1;
      if (send_c) tx_data_q <= byte_c;
      new_tx_data_q <= send_c;
      tx_last_q     <= done_c_o;
    end
  end

  assign tx_data_o      = tx_data_q;
  assign new_tx_data_o  = new_tx_data_q;
  assign tx_last_byte_o = tx_last_q;
endmodule

// File: rtl/siacmd_parser.sv
// UART byte parser (0xAA frames -> work/target, loop echo) and nonce/loop reply framer.
// Optional inter-byte RX timeout enabled by defining SIACMD_RX_TIMEOUT_EN.
module siacmd_parser
  import siacmd_pkg::*;
`ifdef SIACMD_RX_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYC = 1000000
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                new_rx_data,
  output logic [7:0]          tx_data,
  output logic                new_tx_data,
  input  logic                tx_busy,
  output logic [WORK_W-1:0]   work,
  output logic [TARGET_W-1:0] target,
  output logic                work_valid,
  input  logic [31:0]         nonce,
  input  logic                nonce_valid,
  output logic                nonce_ready,
  output logic                rx_last_byte,
  output logic                tx_last_byte
);
  rx_state_e           rx_state_q, rx_state_d;
  logic [7:0]          cmd_q, len_q, cnt_q, loop_byte_q;
  logic [ASM_W-1:0]    asm_q;
  logic [WORK_W-1:0]   work_q;
  logic [TARGET_W-1:0] target_q;
  logic                work_valid_q, loop_pend_q, nonce_pend_q, serving_nonce_q;
  logic [31:0]         nonce_q;
  logic                work_frame_c, loop_frame_c, data_byte_c, work_done_c, loop_done_c;
  logic                timeout_c, tx_req_c, tx_ack_c, tx_done_c;
  logic [7:0]          wr_idx_c;
  tx_req_t             tx_sel_c;

`ifdef SIACMD_RX_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  // Cycles since the last received byte, saturating at the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  to_cnt_q <= 32'd0;
    else if (new_rx_data)                     to_cnt_q <= 32'd0;
    else if (to_cnt_q != 32'(TIMEOUT_CYC))    to_cnt_q <= to_cnt_q + 32'd1;
  end

  assign timeout_c = (rx_state_q != R_IDLE) && !new_rx_data && (to_cnt_q == 32'(TIMEOUT_CYC));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_q <= R_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    if (timeout_c) begin
      rx_state_d = R_IDLE;
    end else if (new_rx_data) begin
      case (rx_state_q)
        R_IDLE:  if (rx_data == HDR_RX) rx_state_d = R_CMD;
        R_CMD:   rx_state_d = R_LEN;
        R_LEN:   rx_state_d = (rx_data == 8'd0) ? R_IDLE : R_DATA;
        R_DATA:  if (cnt_q == 8'd1) rx_state_d = R_IDLE;
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    work_frame_c = (cmd_q == CMD_WORK) && (len_q == 8'(WORK_LEN));
    loop_frame_c = (cmd_q == CMD_LOOP) && (len_q == 8'd1);
    data_byte_c  = new_rx_data && (rx_state_q == R_DATA);
    rx_last_byte = new_rx_data && (((rx_state_q == R_DATA) && (cnt_q == 8'd1)) ||
                                   ((rx_state_q == R_LEN) && (rx_data == 8'd0)));
    work_done_c  = data_byte_c && (cnt_q == 8'd1) && work_frame_c;
    loop_done_c  = data_byte_c && (cnt_q == 8'd1) && loop_frame_c;
    wr_idx_c     = len_q - cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q        <= 8'h00;
      len_q        <= 8'h00;
      cnt_q        <= 8'h00;
      asm_q        <= '0;
      work_q       <= '0;
      target_q     <= '0;
      work_valid_q <= 1'b0;
    end else begin
      if (new_rx_data && rx_state_q == R_CMD) cmd_q <= rx_data;
      if (new_rx_data && rx_state_q == R_LEN) begin
        len_q <= rx_data;
        cnt_q <= rx_data;
      end
      if (data_byte_c) cnt_q <= cnt_q - 8'd1;
      if (data_byte_c && work_frame_c && cnt_q != 8'd1) asm_q[{wr_idx_c, 3'b000} +: 8] <= rx_data;
      if (work_done_c) begin
        work_q   <= asm_q[WORK_W-1:0];
        target_q <= {rx_data, asm_q[ASM_W-1:WORK_W]};
      end
      work_valid_q <= work_done_c;
    end
  end

  // Reply bookkeeping: loop slot frees on acceptance, nonce slot only once its reply is fully sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_byte_q     <= 8'h00;
      loop_pend_q     <= 1'b0;
      nonce_q         <= 32'd0;
      nonce_pend_q    <= 1'b0;
      serving_nonce_q <= 1'b0;
    end else begin
      if (loop_done_c) begin
        loop_byte_q <= rx_data;
        loop_pend_q <= 1'b1;
      end else if (tx_ack_c && !nonce_pend_q) begin
        loop_pend_q <= 1'b0;
      end
      if (nonce_valid && !nonce_pend_q) begin
        nonce_q      <= nonce;
        nonce_pend_q <= 1'b1;
      end else if (tx_done_c && serving_nonce_q) begin
        nonce_pend_q <= 1'b0;
      end
      if (tx_ack_c) serving_nonce_q <= nonce_pend_q;
    end
  end

  always_comb begin
    tx_req_c = nonce_pend_q || loop_pend_q;
    if (nonce_pend_q) begin
      tx_sel_c.cmd     = CMD_WORK;
      tx_sel_c.len     = 8'(NONCE_LEN);
      tx_sel_c.payload = nonce_q;
    end else begin
      tx_sel_c.cmd     = CMD_LOOP;
      tx_sel_c.len     = 8'd1;
      tx_sel_c.payload = {24'd0, loop_byte_q};
    end
  end

  siacmd_tx_framer u_tx (
    .clk           (clk),
    .rst           (rst),
    .req_i         (tx_req_c),
    .req_data_i    (tx_sel_c),
    .tx_busy_i     (tx_busy),
    .ack_c_o       (tx_ack_c),
    .done_c_o      (tx_done_c),
    .tx_data_o     (tx_data),
    .new_tx_data_o (new_tx_data),
    .tx_last_byte_o(tx_last_byte)
  );

  assign work        = work_q;
  assign target      = target_q;
  assign work_valid  = work_valid_q;
  assign nonce_ready = ~nonce_pend_q;
endmodule

// File: doc/siacmd_parser.md
Name: siacmd_parser

Overview:
- Byte-level command parser and response framer between the UART core and siacore, inside the uart2core wrapper.
- RX side: consumes received bytes, decodes frames of the form 0xAA, cmd, len, payload, and emits a 640-bit work block plus a 64-bit target.
- TX side: serialises found-nonce and loop-test replies as frames of the form 0x55, cmd, len, payload, one byte per UART handshake.

Parameters:
- WORK_W, 640, work block width in bits (80 bytes).
- TARGET_W, 64, target width in bits (8 bytes).
- WORK_LEN, 88, required payload length of a work command, (WORK_W+TARGET_W)/8.
- TIMEOUT_CYC, 1000000, inter-byte RX timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from the UART receiver
- new_rx_data  in  1  one-cycle strobe: rx_data is valid
- tx_data  out  8  byte to the UART transmitter
- new_tx_data  out  1  one-cycle strobe: send tx_data
- tx_busy  in  1  UART transmitter is busy
- work  out  WORK_W  assembled work block
- target  out  TARGET_W  assembled target
- work_valid  out  1  one-cycle pulse: work/target updated
- nonce  in  32  found nonce from siacore
- nonce_valid  in  1  nonce is offered
- nonce_ready  out  1  nonce buffer is empty
- rx_last_byte  out  1  high while the current rx byte is the last byte of a frame
- tx_last_byte  out  1  high while tx_data is the last byte of a frame

Behaviour:
- Reset values: all outputs 0, except nonce_ready=1. RX and TX FSMs are in IDLE; buffers are empty.
- RX FSM states: R_IDLE, R_CMD, R_LEN, R_DATA. Transitions occur only on new_rx_data.
  - R_IDLE: byte 0xAA -> R_CMD; any other byte is ignored.
  - R_CMD: latch cmd -> R_LEN.
  - R_LEN: latch len. len=0 -> R_IDLE (frame complete, no action). Otherwise load byte counter = len -> R_DATA.
  - R_DATA: decrement counter per byte; counter reaching 0 -> R_IDLE.
- Work frame (cmd 0x00, len=WORK_LEN):
  - Payload byte i (0-based) is written to bits [8i+7:8i] of a 704-bit assembly register, so byte 0 is the LSB.
  - On the last byte: work <= asm[639:0], target <= asm[703:640], and work_valid pulses on the following cycle.
  - work and target hold their values until the next complete work frame.
- Loop frame (cmd 0x01, len=1): latch the payload byte and set loop_pend.
- Discarded frames: cmd 0x00 with len != WORK_LEN, cmd 0x01 with len != 1, and any other cmd. The payload is counted and discarded, with no output effect.
- rx_last_byte = new_rx_data AND (in R_DATA with counter=1, or in R_LEN with incoming len=0).
- Nonce buffer: on nonce_valid & nonce_ready, latch nonce and set nonce_pend. nonce_ready = ~nonce_pend. Cleared after the last byte of the nonce reply is sent.
- TX FSM states: T_IDLE, T_HDR, T_CMD, T_LEN, T_DATA.
  - In T_IDLE, if nonce_pend select reply cmd 0x00 len 4; else if loop_pend select cmd 0x01 len 1. Nonce has priority.
  - Each state emits one byte: 0x55, cmd, len, then payload.
  - Nonce payload is sent LSB byte first: nonce[7:0], then [15:8], [23:16], [31:24]. Loop payload is the echoed byte.
  - A byte is issued only when tx_busy=0 and no strobe was issued in the previous cycle. new_tx_data is a 1-cycle pulse and tx_data is held stable until the next strobe.
  - tx_last_byte is asserted with the strobe of the final payload byte.
  - Frames are never interleaved. Return to T_IDLE after the final byte.
- A loop frame arriving while loop_pend=1 overwrites the stored byte (last one wins). Reception of new frames continues while TX is active.
- A nonce offered during the nonce reply's own transmission is stalled (nonce_ready=0) until that reply completes.
- Asynchronous rst mid-frame: both FSMs return to IDLE immediately, buffers clear, and work/target go to 0.

Optional Feature:
- Macro: SIACMD_RX_TIMEOUT_EN.
- When defined: a counter clears on every new_rx_data. If the RX FSM is in R_CMD, R_LEN or R_DATA and the counter reaches TIMEOUT_CYC, the FSM returns to R_IDLE and the partial frame is dropped (no work_valid).
- When undefined: no counter, and a partial frame waits indefinitely.

Decomposition:
- Shared package siacmd_pkg:
  - HDR_RX=8'hAA, HDR_TX=8'h55
  - CMD_WORK=8'h00, CMD_LOOP=8'h01
  - WORK_LEN=88, NONCE_LEN=4
  - RX and TX state enums
- Natural sub-module: siacmd_tx_framer, containing the TX FSM and byte mux, driven by {req, cmd, len, payload[31:0]}.

Test Plan:
- Reset, then frame AA 00 58 + 88 bytes 0x00..0x57 -> one work_valid pulse; work[7:0]=0x00, work[639:632]=0x4F, target[7:0]=0x50, target[63:56]=0x57.
- Frame AA 01 01 3C -> TX sends 55 01 01 3C; tx_last_byte on the 3C strobe; no work_valid.
- nonce=0x12345678 offered, tx_busy held 1 for 50 cycles -> TX sends 55 00 04 78 56 34 12; nonce_ready stays low until the 12 byte is strobed.
- Loop frame and nonce made pending in the same cycle -> nonce frame is sent first, then 55 01 01 xx; no interleaving.
- Discard and resync: AA 00 05 + 5 bytes, then AA 07 02 + 2 bytes -> no work_valid and no TX; a following valid work frame is accepted. Stray 0x11 bytes before 0xAA are ignored.
- rst asserted after byte 40 of a work frame, then a full frame -> only one work_valid, carrying the second frame's data. With SIACMD_RX_TIMEOUT_EN and TIMEOUT_CYC=100, a 101-cycle stall after byte 10 -> frame dropped and the next 0xAA is accepted.
